// File: rtl/branch_predict_unit.sv
// Fetch-stage branch predictor: gshare direction table, direct-mapped BTB, and next-PC select.
// Optional statistics counters are compiled in with BPU_STATS_EN.
module branch_predict_unit #(
   parameter int BHR_BITS     = 3,
   parameter int PHT_IDX_BITS = 5,
   parameter int BTB_IDX_BITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [31:0]         fetch_pc,
   output logic                pred_taken,
   output logic [31:0]         pred_target,
   output logic [BHR_BITS-1:0] pred_bhr,
   input  logic                ex_is_branch,
   input  logic                ex_is_jump,
   input  logic [31:0]         ex_pc,
   input  logic                ex_taken,
   input  logic [31:0]         ex_target,
   input  logic                ex_pred_taken,
   input  logic [BHR_BITS-1:0] ex_pred_bhr,
   input  logic                ex_addr_ok,
`ifdef BPU_STATS_EN
   output logic [31:0]         stat_total,
   output logic [31:0]         stat_correct,
   output logic [31:0]         stat_incorrect,
   input  logic                clr_total,
   input  logic                clr_correct,
   input  logic                clr_incorrect,
`endif
   output logic [31:0]         next_pc,
   output logic                redirect
);

   localparam int PHT_N = 1 << PHT_IDX_BITS;
   localparam int BTB_N = 1 << BTB_IDX_BITS;
   localparam int TAG_W = 30 - BTB_IDX_BITS;

   logic [1:0]              pht_q [PHT_N];
   logic [BHR_BITS-1:0]     bhr_q;
   logic [BTB_N-1:0]        btb_valid_q;
   logic [TAG_W-1:0]        btb_tag_q [BTB_N];
   logic [31:0]             btb_tgt_q [BTB_N];

   logic                    ex_ctrl, ex_tk, ex_ptk;
   logic [PHT_IDX_BITS-1:0] f_pht_idx, u_pht_idx;
   logic [BTB_IDX_BITS-1:0] f_btb_idx, u_btb_idx;
   logic [TAG_W-1:0]        f_tag;
   logic                    btb_hit, gshare_taken;
   logic [1:0]              pht_upd_d;
   logic [1:0]              sel;
   logic                    unused_pc_lsb;

   assign unused_pc_lsb = ^{fetch_pc[1:0], ex_pc[1:0]};

   // Non-control instructions must never look taken to the selector or the fill logic.
   assign ex_ctrl = ex_is_branch | ex_is_jump;
   assign ex_tk   = ex_ctrl & ex_taken;
   assign ex_ptk  = ex_ctrl & ex_pred_taken;

   assign f_pht_idx    = fetch_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(bhr_q);
   assign gshare_taken = pht_q[f_pht_idx][1];
   assign f_btb_idx    = fetch_pc[BTB_IDX_BITS+1:2];
   assign f_tag        = fetch_pc[31:BTB_IDX_BITS+2];
   assign btb_hit      = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);

   assign pred_taken  = gshare_taken & btb_hit;
   assign pred_target = btb_tgt_q[f_btb_idx];
   assign pred_bhr    = bhr_q;

   always_comb begin
      sel = 2'd0;
      unique case ({ex_tk, ex_ptk})
         2'b00:   sel = pred_taken ? 2'd1 : 2'd0;
         2'b01:   sel = 2'd2;
         2'b10:   sel = 2'd3;
         default: sel = ex_addr_ok ? (pred_taken ? 2'd1 : 2'd0) : 2'd3;
      endcase
   end

   always_comb begin
      next_pc = fetch_pc + 32'd4;
      unique case (sel)
         2'd0:    next_pc = fetch_pc + 32'd4;
         2'd1:    next_pc = pred_target;
         2'd2:    next_pc = ex_pc + 32'd4;
         default: next_pc = ex_target;
      endcase
   end

   assign redirect = sel[1];

   // Training uses the history the branch saw at fetch, not the current BHR.
   assign u_pht_idx = ex_pc[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ex_pred_bhr);

   always_comb begin
      pht_upd_d = pht_q[u_pht_idx];
      if (ex_taken && pht_q[u_pht_idx] != 2'b11)
         pht_upd_d = pht_q[u_pht_idx] + 2'b01;
      else if (!ex_taken && pht_q[u_pht_idx] != 2'b00)
         pht_upd_d = pht_q[u_pht_idx] - 2'b01;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
         bhr_q <= '0;
      end else if (ex_is_branch) begin
         pht_q[u_pht_idx] <= pht_upd_d;
         bhr_q            <= {bhr_q[BHR_BITS-2:0], ex_taken};
      end
   end

   assign u_btb_idx = ex_pc[BTB_IDX_BITS+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         btb_valid_q <= '0;
      else if (ex_tk)
         btb_valid_q[u_btb_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (ex_tk) begin
         btb_tag_q[u_btb_idx] <= ex_pc[31:BTB_IDX_BITS+2];
         btb_tgt_q[u_btb_idx] <= ex_target;
      end
   end

`ifdef BPU_STATS_EN
   logic [31:0] total_q, correct_q, incorrect_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_q     <= '0;
         correct_q   <= '0;
         incorrect_q <= '0;
      end else begin
         if (clr_total)                  total_q     <= '0;
         else if (ex_ctrl)               total_q     <= total_q + 32'd1;
         if (clr_correct)                correct_q   <= '0;
         else if (ex_ctrl && !redirect)  correct_q   <= correct_q + 32'd1;
         if (clr_incorrect)              incorrect_q <= '0;
         else if (ex_ctrl && redirect)   incorrect_q <= incorrect_q + 32'd1;
      end
   end

   assign stat_total     = total_q;
   assign stat_correct   = correct_q;
   assign stat_incorrect = incorrect_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit; define BPU_STATS_EN to also cover the statistics counters.
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [2:0]  pred_bhr;
   logic        ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken, ex_addr_ok;
   logic [31:0] ex_pc, ex_target;
   logic [2:0]  ex_pred_bhr;
   logic [31:0] next_pc;
   logic        redirect;
`ifdef BPU_STATS_EN
   logic [31:0] stat_total, stat_correct, stat_incorrect;
   logic        clr_total, clr_correct, clr_incorrect;
`endif

   int n_cmp = 0;
   int n_err = 0;

   branch_predict_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_pc      (fetch_pc),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .pred_bhr      (pred_bhr),
      .ex_is_branch  (ex_is_branch),
      .ex_is_jump    (ex_is_jump),
      .ex_pc         (ex_pc),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_pred_taken (ex_pred_taken),
      .ex_pred_bhr   (ex_pred_bhr),
      .ex_addr_ok    (ex_addr_ok),
`ifdef BPU_STATS_EN
      .stat_total    (stat_total),
      .stat_correct  (stat_correct),
      .stat_incorrect(stat_incorrect),
      .clr_total     (clr_total),
      .clr_correct   (clr_correct),
      .clr_incorrect (clr_incorrect),
`endif
      .next_pc       (next_pc),
      .redirect      (redirect)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic ex_set(input logic b, input logic j, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic ptk, input logic [2:0] pbhr,
                         input logic aok);
      ex_is_branch  = b;
      ex_is_jump    = j;
      ex_pc         = pc;
      ex_taken      = tk;
      ex_target     = tgt;
      ex_pred_taken = ptk;
      ex_pred_bhr   = pbhr;
      ex_addr_ok    = aok;
   endtask

   task automatic ex_idle();
      ex_set(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      fetch_pc = 32'h100;
      ex_idle();
`ifdef BPU_STATS_EN
      clr_total = 1'b0; clr_correct = 1'b0; clr_incorrect = 1'b0;
`endif
      #17 rst_n = 1'b1;
      tick();

      // Reset state, idle execute stage
      chk("rst_pred_taken", 32'(pred_taken), 32'd0);
      chk("rst_pred_bhr",   32'(pred_bhr),   32'd0);
      chk("rst_next_pc",    next_pc,         32'h104);
      chk("rst_redirect",   32'(redirect),   32'd0);

      // Unpredicted taken branch: recover to ex_target, trains PHT[0], fills BTB[0]
      ex_set(1'b1, 1'b0, 32'h200, 1'b1, 32'h300, 1'b0, 3'd0, 1'b0);
      #1;
      chk("tk_np_next_pc",  next_pc,       32'h300);
      chk("tk_np_redirect", 32'(redirect), 32'd1);
      tick();
      chk("bhr_after_1", 32'(pred_bhr), 32'd1);

      // Two more taken resolves with carried history 7 push PHT[7] to 11
      for (int i = 0; i < 2; i++) begin
         ex_set(1'b1, 1'b0, 32'h200, 1'b1, 32'h300, 1'b0, 3'd7, 1'b0);
         #1;
         chk("tk_np_next_pc2", next_pc, 32'h300);
         tick();
      end
      ex_idle();
      fetch_pc = 32'h200;
      #1;
      chk("pred_bhr_111",    32'(pred_bhr),   32'd7);
      chk("pred_taken_hit",  32'(pred_taken), 32'd1);
      chk("pred_target_hit", pred_target,     32'h300);
      chk("pred_next_pc",    next_pc,         32'h300);
      chk("pred_redirect",   32'(redirect),   32'd0);

      // Predicted taken, actually not taken: four decrements floor PHT[7] at 00
      fetch_pc = 32'h100;
      for (int i = 0; i < 4; i++) begin
         ex_set(1'b1, 1'b0, 32'h200, 1'b0, 32'h300, 1'b1, 3'd7, 1'b0);
         #1;
         chk("nt_p_next_pc",  next_pc,       32'h204);
         chk("nt_p_redirect", 32'(redirect), 32'd1);
         tick();
      end
      chk("bhr_after_nt", 32'(pred_bhr), 32'd0);

      // One taken at 0x218 with history 1 hits PHT[7] again: 00 -> 01 (not 11 if floor is broken)
      ex_set(1'b1, 1'b0, 32'h218, 1'b1, 32'h500, 1'b0, 3'd1, 1'b0);
      #1;
      chk("tk218_next_pc", next_pc, 32'h500);
      tick();
      ex_idle();
      fetch_pc = 32'h218;
      #1;
      chk("floor_pred_taken", 32'(pred_taken), 32'd0);
      chk("floor_pred_tgt",   pred_target,     32'h500);
      chk("floor_next_pc",    next_pc,         32'h21c);

      // Predicted taken, taken, wrong address: recover to ex_target (jump, leaves gshare alone)
      fetch_pc = 32'h100;
      ex_set(1'b0, 1'b1, 32'h240, 1'b1, 32'h400, 1'b1, 3'd0, 1'b0);
      #1;
      chk("badaddr_next_pc",  next_pc,       32'h400);
      chk("badaddr_redirect", 32'(redirect), 32'd1);
      ex_addr_ok = 1'b1;
      #1;
      chk("okaddr_next_pc",  next_pc,       32'h104);
      chk("okaddr_redirect", 32'(redirect), 32'd0);
      tick();

      // BTB alias: 0x240 replaced 0x200 in entry 0
      ex_idle();
      fetch_pc = 32'h200;
      #1;
      chk("alias_200_taken", 32'(pred_taken), 32'd0);
      chk("alias_200_next",  next_pc,         32'h204);
      fetch_pc = 32'h240;
      #1;
      chk("alias_240_tgt",   pred_target,     32'h400);
      chk("jump_keeps_bhr",  32'(pred_bhr),   32'd1);

      // Non-control instruction: taken flags must be ignored, no BTB fill
      fetch_pc = 32'h100;
      ex_set(1'b0, 1'b0, 32'h100, 1'b1, 32'h700, 1'b1, 3'd0, 1'b0);
      #1;
      chk("noctrl_next_pc",  next_pc,       32'h104);
      chk("noctrl_redirect", 32'(redirect), 32'd0);
      tick();
      ex_idle();
      #1;
      chk("noctrl_no_fill", pred_target === 32'h700 ? 32'd1 : 32'd0, 32'd0);

`ifdef BPU_STATS_EN
      clr_total = 1'b1; clr_correct = 1'b1; clr_incorrect = 1'b1;
      tick();
      clr_total = 1'b0; clr_correct = 1'b0; clr_incorrect = 1'b0;
      chk("stat_clr_total", stat_total, 32'd0);
      ex_set(1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
      tick();
      for (int i = 0; i < 2; i++) begin
         ex_set(1'b1, 1'b0, 32'h304, 1'b1, 32'h600, 1'b0, 3'd0, 1'b0);
         tick();
      end
      ex_idle();
      #1;
      chk("stat_total",     stat_total,     32'd3);
      chk("stat_correct",   stat_correct,   32'd1);
      chk("stat_incorrect", stat_incorrect, 32'd2);
      ex_set(1'b1, 1'b0, 32'h300, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0);
      clr_total = 1'b1;
      tick();
      clr_total = 1'b0;
      ex_idle();
      chk("stat_clr_prio",   stat_total,   32'd0);
      chk("stat_correct_2",  stat_correct, 32'd2);
`endif

      // Reset mid-operation: state held at reset until the first edge with rst_n high
      #2 rst_n = 1'b0;
      ex_set(1'b1, 1'b0, 32'h200, 1'b1, 32'h300, 1'b0, 3'd0, 1'b0);
      fetch_pc = 32'h240;
      #1;
      chk("mid_rst_bhr",   32'(pred_bhr),   32'd0);
      chk("mid_rst_taken", 32'(pred_taken), 32'd0);
      tick();
      #2 rst_n = 1'b1;
      #1;
      chk("post_rst_bhr_hold", 32'(pred_bhr), 32'd0);
      tick();
      chk("post_rst_bhr_upd",  32'(pred_bhr), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
